// File: rtl/vout_ctrl_pkg.sv
// Shared types and constants for the video output controller.
package vout_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Byte address of a pixel is x scaled by the 4-byte pixel stride.
    localparam int unsigned X_SHIFT = 2;

    // FIFO entry layout: {sof, eol, pixel[15:0]}.
    localparam int unsigned FIFO_WIDTH  = 18;
    localparam int unsigned TAG_EOL_BIT = 16;
    localparam int unsigned TAG_SOF_BIT = 17;

    // Pack a frame-buffer read address; the x byte offset wraps at 16 bits.
    function automatic logic [31:0] pack_addr(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] xs;
        xs = x << X_SHIFT;
        return {y, xs};
    endfunction

endpackage

// File: rtl/vout_fifo.sv
// Synchronous FIFO with full/empty flags and occupancy count.
module vout_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign pop_dat = mem[rd_ptr_q];

    // A pop frees a slot, so a push alongside a pop is accepted even when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; contents need no reset, only the pointers do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vout_ctrl.sv
// Video output controller: reads a frame from a fixed-latency frame buffer
// and streams tagged pixels through an output FIFO with backpressure.
module vout_ctrl
    import vout_ctrl_pkg::*;
#(
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        vout_clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [15:0] vout_xres,
    input  logic [15:0] vout_yres,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic [15:0] rd_dat,
    output logic        vout_valid,
    output logic [15:0] vout_dat,
    output logic        vout_sof,
    output logic        vout_eol,
    input  logic        vout_ready,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e          state_q;
    logic [15:0]     xres_q;
    logic [15:0]     yres_q;
    logic [15:0]     x_q;
    logic [15:0]     y_q;
    logic            frame_done_q;

    logic [RD_LAT-1:0] pipe_v_q;
    logic [RD_LAT-1:0] pipe_sof_q;
    logic [RD_LAT-1:0] pipe_eol_q;

    logic [FIFO_WIDTH-1:0] fifo_wdat;
    logic [FIFO_WIDTH-1:0] fifo_rdat;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic [CW-1:0]         fifo_count;

    logic [31:0] inflight;
    logic [31:0] occupancy;
    logic        req;
    logic        last_x;
    logic        last_y;

    // Count reads still travelling through the latency pipeline.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            if (pipe_v_q[i]) begin
                inflight = inflight + 32'd1;
            end
        end
    end

    assign occupancy = inflight + 32'(fifo_count);
    assign last_x    = (x_q == xres_q - 16'd1);
    assign last_y    = (y_q == yres_q - 16'd1);

    // Only issue a read when a FIFO slot is guaranteed for its data.
    assign req       = (state_q == StRun) && (occupancy < FIFO_DEPTH) && !fifo_full;

    assign rd_req     = req;
    assign rd_addr    = req ? pack_addr(x_q, y_q) : 32'd0;
    assign busy       = (state_q != StIdle);
    assign frame_done = frame_done_q;

    // Frame FSM with x/y scan counters and the registered done pulse.
    always_ff @(posedge vout_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            xres_q       <= '0;
            yres_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (frame_start) begin
                        if (vout_xres != 16'd0 && vout_yres != 16'd0) begin
                            xres_q  <= vout_xres;
                            yres_q  <= vout_yres;
                            x_q     <= '0;
                            y_q     <= '0;
                            state_q <= StRun;
                        end else begin
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (req) begin
                        if (last_x) begin
                            x_q <= '0;
                            y_q <= y_q + 16'd1;
                            if (last_y) begin
                                state_q <= StDrain;
                            end
                        end else begin
                            x_q <= x_q + 16'd1;
                        end
                    end
                end
                StDrain: begin
                    if (inflight == 32'd0 && fifo_empty) begin
                        state_q      <= StIdle;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Valid/tag pipeline matching the frame-buffer read latency.
    always_ff @(posedge vout_clk) begin
        if (rst) begin
            pipe_v_q   <= '0;
            pipe_sof_q <= '0;
            pipe_eol_q <= '0;
        end else begin
            pipe_v_q[0]   <= req;
            pipe_sof_q[0] <= (x_q == 16'd0) && (y_q == 16'd0);
            pipe_eol_q[0] <= last_x;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i]   <= pipe_v_q[i-1];
                pipe_sof_q[i] <= pipe_sof_q[i-1];
                pipe_eol_q[i] <= pipe_eol_q[i-1];
            end
        end
    end

    // Assemble the FIFO entry from returning data and its tags.
    always_comb begin
        fifo_wdat              = '0;
        fifo_wdat[15:0]        = rd_dat;
        fifo_wdat[TAG_EOL_BIT] = pipe_eol_q[RD_LAT-1];
        fifo_wdat[TAG_SOF_BIT] = pipe_sof_q[RD_LAT-1];
    end

    assign fifo_pop = !fifo_empty && vout_ready;

    vout_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (vout_clk),
        .rst      (rst),
        .push     (pipe_v_q[RD_LAT-1]),
        .push_dat (fifo_wdat),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rdat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Outputs read as zero when nothing is available so reset state is clean.
    assign vout_valid = !fifo_empty;
    assign vout_dat   = vout_valid ? fifo_rdat[15:0] : 16'd0;
    assign vout_sof   = vout_valid ? fifo_rdat[TAG_SOF_BIT] : 1'b0;
    assign vout_eol   = vout_valid ? fifo_rdat[TAG_EOL_BIT] : 1'b0;

endmodule
